async_fork_fifo: RTL and testbench
==================================

ASYNC_FORK_FIFO -- requirements
Module: async_fork_fifo

Interface
REQ-001 The block SHALL have parameter data_width, default 32, giving the token data width.
REQ-002 The block SHALL have parameter depth, default 4, giving token storage entries; legal range is 2 to 64.
REQ-003 The block SHALL have parameter output_size, default 2, giving the number of downstream consumer ports.
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-low reset.
REQ-006 Port req_l: output, 1 bit, upstream request to the producer side.
REQ-007 Port ack_l: input, 1 bit, upstream one-cycle acknowledge; din is valid in that cycle.
REQ-008 Port din: input, data_width bits, upstream token data.
REQ-009 Port req_r: input, output_size bits, per-consumer request.
REQ-010 Port ack_r: output, output_size bits, per-consumer one-cycle acknowledge.
REQ-011 Port dout: output, data_width bits, token data, valid whenever any ack_r bit is high.
REQ-012 Port level: output, 32 bits, number of stored tokens, range 0 to depth.

Function
REQ-013 Upstream, the block SHALL act as requester: next req_l = ~ack_l & (level_next < depth).
REQ-014 A token SHALL be written at the tail on any rising edge with ack_l=1 and req_l=1; ack_l while req_l=0 SHALL be ignored.
REQ-015 Downstream, the block SHALL act as responder to each port i independently: issue ack_r[i]=1 for exactly one cycle when req_r[i]=1, ack_r[i]=0, served[i]=0 and level>0.
REQ-016 served is an output_size-bit register; a port's bit SHALL be set when its ack is issued, so each consumer receives each token exactly once.
REQ-017 dout SHALL be registered and loaded with the head entry on every edge that issues any ack_r bit; otherwise it holds.
REQ-018 The head SHALL pop on the edge where served, including bits set that edge, becomes all ones; served SHALL clear to 0 on that same edge.
REQ-019 Consumers SHALL be able to be served on different cycles; a slow consumer stalls the pop and blocks the head, not the other consumers' already-issued acks.
REQ-020 Latency: a token written at edge E SHALL be ackable no earlier than edge E+1 (ack_r high in cycle after E+1 edge).
REQ-021 Back-to-back: a single port SHALL receive at most one ack every two cycles; different ports MAY be acked in the same cycle.
REQ-022 Simultaneous write and pop SHALL leave level unchanged; full (level=depth) with pop SHALL still accept a write only through the req_l rule (no overflow).
REQ-023 Read/write pointers SHALL wrap from depth-1 to 0; depth need not be a power of two.
REQ-024 Token order SHALL be preserved: dout sequence on every port equals din sequence.

Reset
REQ-025 While rst=0: req_l=0, ack_r=0, dout=0, level=0, served=0, pointers=0, independent of clk.
REQ-026 Reset mid-operation SHALL discard all stored tokens and partial served state; an ack_l arriving after release with req_l=0 SHALL be ignored.
REQ-027 After rst release, req_l SHALL rise on the first rising clk edge.

Verification
REQ-028 Producer tokens 0..9, both consumers req_r=11 always -> each port receives 0..9 in order, level never exceeds 1-2, no duplicate acks.
REQ-029 req_r=01 (port 1 idle), 6 tokens offered -> port 0 gets token 0 only, level reaches 4, req_l stays 0; raise req_r[1] -> port 1 gets 0, pop, then both drain 1..5.
REQ-030 Fill to level=4, then consumers request every cycle while producer acks -> level stays within 3..4 during the simultaneous write/pop phase, pointers wrap without data loss.
REQ-031 Assert rst=0 asynchronously mid-stream with level=3 -> outputs zero immediately; after release the first token delivered is the next producer value, nothing stale.
REQ-032 Inject ack_l while req_l=0 -> level unchanged, no token appears on dout.
REQ-033 Run 5000 tokens with random producer/consumer stalls (fail rate 30%) -> both consumer counts equal 5000, data sequence matches, level never >4.

Source files
------------

// File: rtl/async_fork_fifo.sv
// Token FIFO with a requester-style upstream handshake and a fork to several
// responder-style consumer ports; each consumer sees every token exactly once.
module async_fork_fifo #(
  parameter int unsigned data_width  = 32,
  parameter int unsigned depth       = 4,
  parameter int unsigned output_size = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   req_l,
  input  logic                   ack_l,
  input  logic [data_width-1:0]  din,
  input  logic [output_size-1:0] req_r,
  output logic [output_size-1:0] ack_r,
  output logic [data_width-1:0]  dout,
  output logic [31:0]            level
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = $clog2(depth + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);
  localparam logic [output_size-1:0] all_served = '1;

  logic [data_width-1:0]  mem [depth];
  logic [ptr_w-1:0]       wr_ptr;
  logic [ptr_w-1:0]       rd_ptr;
  logic [cnt_w-1:0]       count_q;
  logic [output_size-1:0] served_q;

  logic [cnt_w-1:0]       count_next_c;
  logic [output_size-1:0] issue_c;
  logic [output_size-1:0] served_set_c;
  logic                   write_c;
  logic                   pop_c;
  logic                   not_empty_c;

  // Handshake decode: a port is acked at most once per head token; the head
  // retires on the edge its last outstanding consumer is acked.
  always_comb begin
    not_empty_c  = (count_q != '0);
    write_c      = ack_l & req_l;
    issue_c      = req_r & ~ack_r & ~served_q & {output_size{not_empty_c}};
    served_set_c = served_q | issue_c;
    pop_c        = not_empty_c & (served_set_c == all_served);
    count_next_c = count_q + cnt_w'(write_c) - cnt_w'(pop_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_l    <= 1'b0;
      ack_r    <= '0;
      dout     <= '0;
      served_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      req_l    <= ~ack_l & (count_next_c < depth_cnt);
      ack_r    <= issue_c;
      served_q <= pop_c ? '0 : served_set_c;
      count_q  <= count_next_c;
      if (|issue_c) begin
        dout <= mem[rd_ptr];
      end
      if (write_c) begin
        wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + ptr_w'(1);
      end
      if (pop_c) begin
        rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ptr_w'(1);
      end
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (write_c) begin
      mem[wr_ptr] <= din;
    end
  end

  assign level = 32'(count_q);

endmodule

// File: tb/tb_async_fork_fifo.sv
// Randomized bench for async_fork_fifo against a token-count reference model.
module tb_async_fork_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NP    = 2;

  logic          clk;
  logic          rst;
  logic          ack_l;
  logic [DW-1:0] din;
  logic [NP-1:0] req_r;
  logic          req_l;
  logic [NP-1:0] ack_r;
  logic [DW-1:0] dout;
  logic [31:0]   level;

  async_fork_fifo #(.data_width(DW), .depth(DEPTH), .output_size(NP)) dut (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
    .req_r(req_r), .ack_r(ack_r), .dout(dout), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: counts of tokens written / received per port.
  int            n_tests;
  int            n_fail;
  int            written;
  int            popped;
  int            rcv [NP];
  logic [DW-1:0] toks [$];
  logic [DW-1:0] last_dout;
  logic [NP-1:0] prev_ack;
  bit            model_req;
  int            max_level;
  int            min_level;
  int            next_tok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    written = 0;
    popped  = 0;
    for (int i = 0; i < NP; i++) rcv[i] = 0;
    toks.delete();
    last_dout = '0;
    prev_ack  = '0;
    model_req = 1'b0;
  endtask

  // One clock: drive inputs, predict from the model, check #1 after the edge.
  task automatic cycle(input bit prod, input logic [DW-1:0] data, input logic [NP-1:0] rr);
    logic [NP-1:0] exp_ack;
    logic [DW-1:0] exp_dout;
    bit            wr;
    bit            exp_req;
    int            lvl;
    int            mn;
    ack_l = prod;
    din   = data;
    req_r = rr;
    wr    = prod && model_req;
    for (int i = 0; i < NP; i++)
      exp_ack[i] = rr[i] && !prev_ack[i] && (rcv[i] == popped) && (written > popped);
    exp_dout = (|exp_ack) ? toks[popped] : last_dout;
    if (wr) begin
      toks.push_back(data);
      written++;
      next_tok++;
    end
    mn = written;
    for (int i = 0; i < NP; i++) begin
      rcv[i] += int'(exp_ack[i]);
      if (rcv[i] < mn) mn = rcv[i];
    end
    popped  = mn;
    lvl     = written - popped;
    exp_req = !prod && (lvl < int'(DEPTH));
    @(posedge clk);
    #1;
    check_eq("ack_r", 32'(ack_r), 32'(exp_ack));
    check_eq("dout", dout, exp_dout);
    check_eq("level", level, 32'(lvl));
    check_eq("req_l", 32'(req_l), 32'(exp_req));
    prev_ack  = exp_ack;
    model_req = exp_req;
    last_dout = exp_dout;
    if (lvl > max_level) max_level = lvl;
    if (lvl < min_level) min_level = lvl;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (written - popped) > 0; k++) cycle(1'b0, '0, 2'b11);
    check_eq("drained", 32'(written - popped), 32'd0);
  endtask

  task automatic release_reset();
    ack_l = 1'b0;
    req_r = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int b0;
    int b1;
    int bw;
    clk = 1'b0; rst = 1'b1; ack_l = 1'b0; din = '0; req_r = '0;
    n_tests = 0; n_fail = 0; next_tok = 0;
    model_reset();

    // Asynchronous reset, observed before any clock edge
    #2 rst = 1'b0;
    #1;
    check_eq("rst_req_l", 32'(req_l), 32'd0);
    check_eq("rst_ack_r", 32'(ack_r), 32'd0);
    check_eq("rst_dout", dout, 32'd0);
    check_eq("rst_level", level, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_level", level, 32'd0);
    release_reset();

    // Tokens 0..9, both consumers always requesting
    max_level = 0;
    bw = written;
    for (int k = 0; k < 100 && (written - bw) < 10; k++)
      cycle(model_req, DW'(next_tok), 2'b11);
    drain();
    check_eq("s1_rcv0", 32'(rcv[0]), 32'd10);
    check_eq("s1_rcv1", 32'(rcv[1]), 32'd10);
    check_eq("s1_maxlvl_le2", 32'(max_level <= 2), 32'd1);

    // Port 1 idle: head blocks, FIFO fills
    b0 = rcv[0]; b1 = rcv[1]; bw = written;
    for (int k = 0; k < 20; k++)
      cycle(model_req && (written - bw) < 6, DW'(next_tok), 2'b01);
    check_eq("s2_level_full", level, 32'(DEPTH));
    check_eq("s2_req_l_low", 32'(req_l), 32'd0);
    check_eq("s2_port0_one", 32'(rcv[0] - b0), 32'd1);
    check_eq("s2_port1_none", 32'(rcv[1] - b1), 32'd0);
    // ack_l while req_l is low must be ignored
    cycle(1'b1, 32'hDEAD_BEEF, 2'b00);
    cycle(1'b1, 32'hDEAD_BEEF, 2'b00);
    check_eq("s2_inject_level", level, 32'(DEPTH));
    for (int k = 0; k < 100 && ((written - bw) < 6 || written > popped); k++)
      cycle(model_req && (written - bw) < 6, DW'(next_tok), 2'b11);
    check_eq("s2_rcv0", 32'(rcv[0] - b0), 32'd6);
    check_eq("s2_rcv1", 32'(rcv[1] - b1), 32'd6);

    // Full FIFO with concurrent write and pop
    for (int k = 0; k < 20 && (written - popped) < int'(DEPTH); k++)
      cycle(model_req, DW'(next_tok), 2'b00);
    check_eq("s3_full", level, 32'(DEPTH));
    min_level = 100; max_level = 0;
    for (int k = 0; k < 40; k++) cycle(model_req, DW'(next_tok) ^ 32'h5A00_0000, 2'b11);
    check_eq("s3_min_ge3", 32'(min_level >= 3), 32'd1);
    check_eq("s3_max_le4", 32'(max_level <= int'(DEPTH)), 32'd1);
    drain();

    // Reset mid-stream at level 3 with an ack in flight
    for (int k = 0; k < 20 && (written - popped) < 3; k++)
      cycle(model_req && (written - popped) < 3, DW'(next_tok) | 32'h0100_0000, 2'b00);
    cycle(1'b0, '0, 2'b01);
    check_eq("s4_level3", level, 32'd3);
    #2 rst = 1'b0;
    #1;
    check_eq("s4_req_l", 32'(req_l), 32'd0);
    check_eq("s4_ack_r", 32'(ack_r), 32'd0);
    check_eq("s4_dout", dout, 32'd0);
    check_eq("s4_level", level, 32'd0);
    release_reset();
    cycle(1'b1, 32'hBAD0_0001, 2'b11);
    b0 = rcv[0]; bw = written;
    for (int k = 0; k < 100 && ((written - bw) < 3 || written > popped); k++)
      cycle(model_req && (written - bw) < 3, DW'(next_tok), 2'b11);
    check_eq("s4_rcv0", 32'(rcv[0] - b0), 32'd3);

    // 5000 tokens with random stalls on both sides
    max_level = 0;
    b0 = rcv[0]; b1 = rcv[1]; bw = written;
    for (int k = 0; k < 60000 && ((rcv[0] - b0) < 5000 || (rcv[1] - b1) < 5000); k++) begin
      logic [NP-1:0] rr;
      for (int i = 0; i < NP; i++) rr[i] = ($urandom_range(99) >= 30);
      cycle(model_req && (written - bw) < 5000 && ($urandom_range(99) >= 30), DW'($urandom), rr);
    end
    check_eq("s5_rcv0", 32'(rcv[0] - b0), 32'd5000);
    check_eq("s5_rcv1", 32'(rcv[1] - b1), 32'd5000);
    check_eq("s5_max_le4", 32'(max_level <= int'(DEPTH)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
